// File: rtl/axis_chk_pkg.sv
// Shared state type, default counter width and saturating increment
// for the AXI-stream counter-pattern checker.
package axis_chk_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } chk_state_t;

  // Callers narrow the result back to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Free-running phase counter; thr_ok drops for one cycle in every READY_PERIOD.
// READY_PERIOD of 0 or 1 leaves thr_ok permanently high.
module axis_ready_throttle #(
  parameter int READY_PERIOD = 4
) (
  input  logic clock,
  input  logic rst_n,
  output logic thr_ok
);

  localparam int PER = (READY_PERIOD > 1) ? READY_PERIOD : 1;
  localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(PER - 1);

  logic [PW-1:0] phase_q, phase_d;

  assign phase_d = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign thr_ok = (PER == 1) || (phase_q != LAST_PH);

endmodule

// File: rtl/axis_cnt_checker.sv
// AXI-stream sink that locks onto an incrementing counter and flags mismatches.
// Outputs update one cycle after the accepting edge; tready is registered and throttled.
module axis_cnt_checker
  import axis_chk_pkg::*;
#(
  parameter int DSIZE        = 10,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int READY_PERIOD = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [DSIZE-1:0] expected,
  output logic             busy
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  chk_state_t       state_q, state_d;
  logic [DSIZE-1:0] exp_q, exp_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             thr_ok;
  logic             acc;
  logic             mism;

  axis_ready_throttle #(
    .READY_PERIOD(READY_PERIOD)
  ) u_thr (
    .clock (clock),
    .rst_n (rst_n),
    .thr_ok(thr_ok)
  );

  assign acc  = s_axis_tvalid & rdy_q;
  assign mism = (s_axis_tdata != exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    errc_d  = errc_q;
    beat_d  = beat_q;
    frame_d = frame_q;

    if (acc) begin
      beat_d = CNT_W'(sat_inc(32'(beat_q), CNT_MAX));
      if (s_axis_tlast) begin
        frame_d = CNT_W'(sat_inc(32'(frame_q), CNT_MAX));
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        // The first beat seeds the pattern, so it can never be an error.
        if (acc) begin
          exp_d   = s_axis_tdata + 1'b1;
          lock_d  = 1'b1;
          state_d = CHECK;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      CHECK, DRAIN: begin
        if (acc) begin
          if (mism) begin
            err_d  = 1'b1;
            errc_d = CNT_W'(sat_inc(32'(errc_q), CNT_MAX));
            exp_d  = s_axis_tdata + 1'b1;
            lock_d = 1'b0;
          end else begin
            exp_d  = exp_q + 1'b1;
            lock_d = 1'b1;
          end
        end
        if (state_q == CHECK) begin
          if (!enable) state_d = (acc && s_axis_tlast) ? IDLE : DRAIN;
        end else if (acc && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) lock_d = 1'b0;

    // Looks at the next state so tready is already low on the first IDLE cycle.
    rdy_d = thr_ok && (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      errc_q  <= '0;
      beat_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      errc_q  <= errc_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign locked        = lock_q;
  assign err_pulse     = err_q;
  assign err_cnt       = errc_q;
  assign beat_cnt      = beat_q;
  assign frame_cnt     = frame_q;
  assign expected      = exp_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_cnt_checker.sv
// Bench: unthrottled narrow-counter instance driven from a vector table,
// throttled instance driven by hand sequences and a randomized source with a model.
module tb_axis_cnt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: no throttle, 4-bit counters
  logic       a_rst_n, a_en, a_vld, a_last;
  logic       a_rdy, a_lock, a_err, a_busy;
  logic [9:0] a_dat, a_exp;
  logic [3:0] a_errc, a_beat, a_frame;

  // Instance B: READY_PERIOD 4, 16-bit counters
  logic        b_rst_n, b_en, b_vld, b_last;
  logic        b_rdy, b_lock, b_err, b_busy;
  logic [9:0]  b_dat, b_exp;
  logic [15:0] b_errc, b_beat, b_frame;

  axis_cnt_checker #(.DSIZE(10), .CNT_W(4), .READY_PERIOD(0)) dut_a (
    .clock(clk), .rst_n(a_rst_n), .enable(a_en),
    .s_axis_tdata(a_dat), .s_axis_tvalid(a_vld), .s_axis_tlast(a_last),
    .s_axis_tready(a_rdy), .locked(a_lock), .err_pulse(a_err),
    .err_cnt(a_errc), .beat_cnt(a_beat), .frame_cnt(a_frame),
    .expected(a_exp), .busy(a_busy)
  );

  axis_cnt_checker #(.DSIZE(10), .CNT_W(16), .READY_PERIOD(4)) dut_b (
    .clock(clk), .rst_n(b_rst_n), .enable(b_en),
    .s_axis_tdata(b_dat), .s_axis_tvalid(b_vld), .s_axis_tlast(b_last),
    .s_axis_tready(b_rdy), .locked(b_lock), .err_pulse(b_err),
    .err_cnt(b_errc), .beat_cnt(b_beat), .frame_cnt(b_frame),
    .expected(b_exp), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  typedef struct {
    bit rst; bit en; bit vld; int dat; bit last;
    bit lock; bit err; int errc; int beat; int frame; int exp; bit busy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rst, input bit en, input bit vld, input int dat, input bit last,
                     input bit lock, input bit err, input int errc, input int beat,
                     input int frame, input int exp, input bit busy);
    tv.push_back(vec_t'{rst, en, vld, dat, last, lock, err, errc, beat, frame, exp, busy});
  endtask

  task automatic send_b(input int d, input bit l);
    bit got;
    got   = 1'b0;
    b_vld = 1'b1;
    b_dat = 10'(d);
    b_last = l;
    for (int w = 0; w < 20 && !got; w++) begin
      got = b_rdy;
      @(posedge clk); #1;
    end
    if (!got) chk($sformatf("send %0d accepted", d), 0, 1);
    b_vld  = 1'b0;
    b_last = 1'b0;
  endtask

  // Reference model state for the randomized run
  int m_st, m_exp, m_errc, m_beat, m_frame;
  bit m_lock, m_err, acc;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wv[6];
    int cnt, cyc, first, lastc, lows, span;

    a_rst_n = 1'b0; a_en = 0; a_vld = 0; a_last = 0; a_dat = '0;
    b_rst_n = 1'b0; b_en = 0; b_vld = 0; b_last = 0; b_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // ---------------- table: rst en vld dat last | lock err errc beat frame exp busy
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0,1);
    for (int k = 0; k < 10; k++) add(0,1,1,k,(k==9), 1,0,0,k+1,(k==9)?1:0,k+1,1);
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0,1);
    wv = '{1020, 1021, 1022, 1023, 0, 1};
    for (int i = 0; i < 6; i++) add(0,1,1,wv[i],0, 1,0,0,i+1,0,(wv[i]+1)%1024,1);
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0,1);
    add(0,1,1,5,0,  1,0,0,1,0,6,1);
    add(0,1,1,6,0,  1,0,0,2,0,7,1);
    add(0,1,1,7,0,  1,0,0,3,0,8,1);
    add(0,1,1,9,0,  0,1,1,4,0,10,1);
    add(0,1,1,10,0, 1,0,1,5,0,11,1);
    add(0,1,0,0,0,  1,0,1,5,0,11,1);
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0,1);
    add(0,1,1,0,0,  1,0,0,1,0,1,1);
    add(0,1,1,1,0,  1,0,0,2,0,2,1);
    add(0,1,1,2,0,  1,0,0,3,0,3,1);
    add(0,0,1,3,0,  1,0,0,4,0,4,1);
    add(0,0,1,4,0,  1,0,0,5,0,5,1);
    add(0,0,1,20,0, 0,1,1,6,0,21,1);
    add(0,0,1,21,0, 1,0,1,7,0,22,1);
    add(0,0,1,22,1, 0,0,1,8,1,23,0);
    add(0,0,1,23,0, 0,0,1,8,1,23,0);
    add(0,1,0,0,0,  0,0,1,8,1,23,1);
    add(0,0,0,0,0,  0,0,1,8,1,23,0);
    add(0,1,0,0,0,  0,0,1,8,1,23,1);
    add(0,1,1,30,0, 1,0,1,9,1,31,1);
    add(0,0,1,31,1, 0,0,1,10,2,32,0);

    foreach (tv[i]) begin
      a_en   = tv[i].en;
      a_vld  = tv[i].vld;
      a_dat  = 10'(tv[i].dat);
      a_last = tv[i].last;
      if (tv[i].rst) a_rst_n = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d locked", i),    32'(a_lock),  32'(tv[i].lock));
      chk($sformatf("vec%0d err_pulse", i), 32'(a_err),   32'(tv[i].err));
      chk($sformatf("vec%0d err_cnt", i),   32'(a_errc),  tv[i].errc);
      chk($sformatf("vec%0d beat_cnt", i),  32'(a_beat),  tv[i].beat);
      chk($sformatf("vec%0d frame_cnt", i), 32'(a_frame), tv[i].frame);
      chk($sformatf("vec%0d expected", i),  32'(a_exp),   tv[i].exp);
      chk($sformatf("vec%0d busy", i),      32'(a_busy),  32'(tv[i].busy));
      chk($sformatf("vec%0d tready", i),    32'(a_rdy),   32'(tv[i].busy));
      a_rst_n = 1'b1;
    end

    // ---------------- saturation of 4-bit counters: constant data, tlast on every beat
    a_rst_n = 1'b0; a_vld = 0; a_en = 0;
    @(posedge clk); #1;
    a_rst_n = 1'b1; a_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      a_vld = 1'b1; a_dat = '0; a_last = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("sat%0d beat_cnt", i),  32'(a_beat),  (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("sat%0d frame_cnt", i), 32'(a_frame), (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("sat%0d err_cnt", i),   32'(a_errc),  (i > 15) ? 15 : i);
      chk($sformatf("sat%0d err_pulse", i), 32'(a_err),   (i > 0) ? 1 : 0);
    end
    a_vld = 1'b0; a_last = 1'b0;

    // ---------------- throttled stream, tvalid held high
    b_en = 1'b1;
    @(posedge clk); #1;
    cnt = 0; cyc = 0; first = -1; lastc = -1;
    while (cnt < 12 && cyc < 40) begin
      b_vld  = 1'b1;
      b_dat  = 10'(cnt);
      b_last = (cnt == 11);
      acc    = b_rdy;
      @(posedge clk); #1;
      if (acc) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        cnt++;
      end
      cyc++;
    end
    b_vld = 1'b0; b_last = 1'b0;
    span = lastc - first + 1;
    chk("thr beats accepted", cnt, 12);
    chk("thr span within 15..16", (span >= 15 && span <= 16) ? 1 : 0, 1);
    chk("thr beat_cnt", 32'(b_beat), 12);
    chk("thr frame_cnt", 32'(b_frame), 1);
    chk("thr err_cnt", 32'(b_errc), 0);
    chk("thr expected", 32'(b_exp), 12);
    chk("thr locked", 32'(b_lock), 1);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (!b_rdy) lows++;
      @(posedge clk); #1;
    end
    chk("thr tready lows per 16", lows, 4);

    // ---------------- reset mid-frame, then reseed at 500
    send_b(12, 1'b0);
    send_b(13, 1'b0);
    chk("pre-rst expected", 32'(b_exp), 14);
    b_vld = 1'b1; b_dat = 10'd14;
    b_rst_n = 1'b0;
    #1;
    chk("rst busy",      32'(b_busy),  0);
    chk("rst locked",    32'(b_lock),  0);
    chk("rst tready",    32'(b_rdy),   0);
    chk("rst err_pulse", 32'(b_err),   0);
    chk("rst err_cnt",   32'(b_errc),  0);
    chk("rst beat_cnt",  32'(b_beat),  0);
    chk("rst frame_cnt", 32'(b_frame), 0);
    chk("rst expected",  32'(b_exp),   0);
    b_vld = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;
    send_b(500, 1'b0);
    chk("seed expected", 32'(b_exp),  501);
    chk("seed locked",   32'(b_lock), 1);
    chk("seed err_cnt",  32'(b_errc), 0);
    chk("seed beat_cnt", 32'(b_beat), 1);

    // ---------------- randomized source against the reference model
    b_rst_n = 1'b0; b_vld = 0; b_last = 0; b_en = 0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    b_en = 1'b1;
    m_st = 0; m_exp = 0; m_errc = 0; m_beat = 0; m_frame = 0; m_lock = 0; m_err = 0;
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(b_vld && !acc)) begin
        b_vld  = ($urandom_range(0, 3) != 0);
        b_dat  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'(m_exp);
        b_last = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 39) == 0) b_en = ~b_en;
      if (m_st == 0) chk($sformatf("rnd%0d idle tready", c), 32'(b_rdy), 0);
      acc = b_vld && b_rdy;

      m_err = 1'b0;
      if (acc) begin
        m_beat = sat16(m_beat);
        if (b_last) m_frame = sat16(m_frame);
      end
      case (m_st)
        0: if (b_en) m_st = 1;
        1: begin
          if (acc) begin
            m_exp = (int'(b_dat) + 1) % 1024; m_lock = 1'b1; m_st = 2;
          end else if (!b_en) m_st = 0;
        end
        default: begin
          if (acc) begin
            if (int'(b_dat) == m_exp) begin
              m_exp = (m_exp + 1) % 1024; m_lock = 1'b1;
            end else begin
              m_err = 1'b1; m_errc = sat16(m_errc);
              m_exp = (int'(b_dat) + 1) % 1024; m_lock = 1'b0;
            end
          end
          if (m_st == 2 && !b_en) m_st = (acc && b_last) ? 0 : 3;
          else if (m_st == 3 && acc && b_last) m_st = 0;
        end
      endcase
      if (m_st == 0) m_lock = 1'b0;

      @(posedge clk); #1;
      chk($sformatf("rnd%0d locked", c),    32'(b_lock),  32'(m_lock));
      chk($sformatf("rnd%0d err_pulse", c), 32'(b_err),   32'(m_err));
      chk($sformatf("rnd%0d err_cnt", c),   32'(b_errc),  m_errc);
      chk($sformatf("rnd%0d beat_cnt", c),  32'(b_beat),  m_beat);
      chk($sformatf("rnd%0d frame_cnt", c), 32'(b_frame), m_frame);
      chk($sformatf("rnd%0d expected", c),  32'(b_exp),   m_exp);
      chk($sformatf("rnd%0d busy", c),      32'(b_busy),  (m_st != 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_cnt_checker.md
Name: axis_cnt_checker

Overview:
- AXI-stream slave that consumes the incrementing-counter stream produced by our counter-pattern source masters.
- Locks onto the first accepted beat and checks every following beat for value +1, modulo 2^DSIZE.
- Applies a programmable tready throttle to exercise master backpressure.
- Reports lock, error and beat/frame statistics.
- Sits at the sink end of test-unit stream paths.

Parameters:
- DSIZE, 10, tdata width and counter pattern width.
- CNT_W, 16, width of the statistic counters.
- READY_PERIOD, 4: tready is low 1 cycle in every READY_PERIOD cycles; 0 or 1 means tready is never throttled.

Ports:
- clock  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start/stop checking.
- s_axis_tdata  input  DSIZE  stream data.
- s_axis_tvalid  input  1  stream valid.
- s_axis_tlast  input  1  end of frame.
- s_axis_tready  output  1  stream ready.
- locked  output  1  checker is synchronised to the pattern.
- err_pulse  output  1  one-cycle pulse on a mismatching beat.
- err_cnt  output  CNT_W  mismatch count, saturating.
- beat_cnt  output  CNT_W  accepted beats, saturating.
- frame_cnt  output  CNT_W  accepted tlast beats, saturating.
- expected  output  DSIZE  next expected data value.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; throttle phase counter 0.
- Handshake:
  - A beat is accepted when s_axis_tvalid and s_axis_tready are both 1 on a rising clock edge.
  - tdata and tlast are sampled only on accepted beats.
  - tready never depends combinationally on tvalid.
- Throttle:
  - Phase counter runs 0..READY_PERIOD-1 continuously outside reset.
  - thr_ok = 0 when phase == READY_PERIOD-1; otherwise thr_ok = 1.
  - s_axis_tready = thr_ok AND (state is SYNC, CHECK or DRAIN); it is registered.
- FSM:
  - IDLE: tready 0. Goes to SYNC when enable = 1.
  - SYNC:
    - On the first accepted beat: expected <= tdata+1; locked <= 1; go to CHECK. No error is possible on this beat.
    - If enable falls before any beat is accepted: go to IDLE.
  - CHECK, on each accepted beat:
    - Match (tdata == expected): expected <= expected+1; locked <= 1.
    - Mismatch: err_pulse = 1 for exactly the next cycle; err_cnt++; expected <= tdata+1 (resync); locked <= 0 until the next matching beat.
    - If enable = 0: go to DRAIN. If an accepted tlast beat coincides with enable = 0, go directly to IDLE.
  - DRAIN: keep checking beats as in CHECK; the accepted tlast beat goes to IDLE.
- Counters:
  - beat_cnt++ on every accepted beat, in SYNC, CHECK and DRAIN.
  - frame_cnt++ on every accepted beat with tlast = 1.
  - All counters saturate at 2^CNT_W-1. They hold their values through IDLE and clear only on reset.
- Arithmetic: expected is computed modulo 2^DSIZE, so 2^DSIZE-1 followed by 0 is a match.
- Simultaneous events: a mismatch on the tlast beat counts as both an error and a frame.
- Latency: every output updates 1 cycle after the accepting edge.
- Reset mid-frame: all state, outputs and counters clear immediately; the next enable re-enters SYNC.
- locked returns to 0 on entering IDLE.

Decomposition:
- Package axis_chk_pkg holds:
  - chk_state_t enum {IDLE, SYNC, CHECK, DRAIN};
  - the saturating-increment function;
  - the default CNT_W constant.
- Sub-module axis_ready_throttle (parameter READY_PERIOD; ports clock, rst_n, thr_ok) holds the phase counter.

Test Plan:
- READY_PERIOD=0, enable=1; source sends 0..9 with tlast on 9 -> locked=1 after the first beat, err_cnt=0, beat_cnt=10, frame_cnt=1, expected=10.
- Stream 1020,1021,1022,1023,0,1 -> no err_pulse; expected=2 (wrap-around).
- Stream 5,6,7,9,10 -> one err_pulse the cycle after beat 9; err_cnt=1; locked 0 for one beat, then 1 after 10; expected=11.
- READY_PERIOD=4, tvalid held high, 12 beats -> tready low every 4th cycle; all 12 beats accepted in 16 cycles; tdata held stable while stalled.
- enable dropped mid-frame at beat 3 of 8 -> DRAIN; beats 4..7 still checked; IDLE after the tlast beat; tready 0 afterwards; frame_cnt=1.
- rst_n asserted mid-frame -> all outputs 0 immediately; re-enable with seed 500 -> SYNC locks, expected=501, err_cnt=0.
